// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: ALU control codes, ALUOp/funct constants and sequencer state type
package alu_ctrl_pkg;
  localparam logic [4:0] ALU_ADD_U = 5'b00000;
  localparam logic [4:0] ALU_ADD_S = 5'b00001;
  localparam logic [4:0] ALU_SUB_U = 5'b00100;
  localparam logic [4:0] ALU_SUB_S = 5'b00101;
  localparam logic [4:0] ALU_MUL_U = 5'b01000;
  localparam logic [4:0] ALU_MUL_S = 5'b01001;
  localparam logic [4:0] ALU_DIV_U = 5'b01100;
  localparam logic [4:0] ALU_DIV_S = 5'b01101;
  localparam logic [4:0] ALU_AND   = 5'b10000;
  localparam logic [4:0] ALU_OR    = 5'b10001;
  localparam logic [4:0] ALU_XOR   = 5'b10010;
  localparam logic [4:0] ALU_SLL   = 5'b10100;
  localparam logic [4:0] ALU_SRL   = 5'b10101;
  localparam logic [4:0] ALU_SRA   = 5'b10110;
  localparam logic [4:0] ALU_EQ    = 5'b11000;
  localparam logic [4:0] ALU_NE    = 5'b11001;
  localparam logic [4:0] ALU_LT_S  = 5'b11010;
  localparam logic [4:0] ALU_GE_S  = 5'b11011;
  localparam logic [4:0] ALU_LT_U  = 5'b11100;
  localparam logic [4:0] ALU_GE_U  = 5'b11101;
  localparam logic [1:0] OP_MEM    = 2'b00;
  localparam logic [1:0] OP_BRANCH = 2'b01;
  localparam logic [1:0] OP_RTYPE  = 2'b10;
  localparam logic [1:0] OP_ITYPE  = 2'b11;
  localparam logic [2:0] F3_ADD    = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  function automatic logic [4:0] base_op(input logic [2:0] f3);
    case (f3)
      F3_ADD:  base_op = ALU_ADD_S;
      F3_SLL:  base_op = ALU_SLL;
      F3_SLT:  base_op = ALU_LT_S;
      F3_SLTU: base_op = ALU_LT_U;
      F3_XOR:  base_op = ALU_XOR;
      F3_SR:   base_op = ALU_SRL;
      F3_OR:   base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational ALUOp/funct3/funct7 to ALU control decode
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [4:0] alu_control,
  output logic [2:0] m_sel,
  output logic       is_mul,
  output logic       is_div,
  output logic       illegal
);
  logic [4:0] br;
  always_comb begin
    case (funct3)
      3'b000:  br = ALU_EQ;
      3'b001:  br = ALU_NE;
      3'b100:  br = ALU_LT_S;
      3'b101:  br = ALU_GE_S;
      3'b110:  br = ALU_LT_U;
      3'b111:  br = ALU_GE_U;
      default: br = ALU_SUB_U;
    endcase
  end
  always_comb begin
    alu_control = ALU_ADD_U;
    m_sel = '0;
    is_mul = 1'b0;
    is_div = 1'b0;
    illegal = 1'b0;
    case (alu_op)
      OP_MEM:    alu_control = ALU_ADD_U;
      OP_BRANCH: alu_control = br;
      OP_RTYPE:
        if (funct7 == F7_BASE) alu_control = base_op(funct3);
        else if (funct7 == F7_ALT && funct3 == F3_ADD) alu_control = ALU_SUB_S;
        else if (funct7 == F7_ALT && funct3 == F3_SR) alu_control = ALU_SRA;
        else if (funct7 == F7_MULDIV) begin
          m_sel = funct3;
          is_div = funct3[2];
          is_mul = !funct3[2];
          alu_control = funct3[2] ? (funct3[0] ? ALU_DIV_U : ALU_DIV_S)
                                  : (funct3 == F3_MULHU ? ALU_MUL_U : ALU_MUL_S);
        end else begin
          illegal = 1'b1;
          alu_control = ALU_ADD_S;
        end
      default: alu_control = (funct3 == F3_SR && funct7[5]) ? ALU_SRA : base_op(funct3);
    endcase
  end
endmodule

// File: rtl/alu_ctrl_sequencer.sv
// alu_ctrl_sequencer: registers decoded ALU control and sequences multi-cycle mul/div ops
module alu_ctrl_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 34
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] alu_control,
  output logic [2:0] m_sel,
  output logic       alu_start,
  output logic       busy,
  output logic       illegal
);
  localparam int CW = $clog2(MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT) + 1;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [4:0] dec_ctrl;
  logic [2:0] dec_msel;
  logic dec_mul, dec_div, dec_ill, acc;
  alu_ctrl_decode u_dec (
    .alu_op(alu_op),
    .funct3(funct3),
    .funct7(funct7),
    .alu_control(dec_ctrl),
    .m_sel(dec_msel),
    .is_mul(dec_mul),
    .is_div(dec_div),
    .illegal(dec_ill)
  );
  assign in_ready = !rst && (state == IDLE || (state == DONE && out_ready));
  assign acc = in_valid && in_ready && !flush;
  assign out_valid = state == DONE;
  assign busy = state == EXEC;
  // counter is loaded with LAT-2 so DONE lands exactly LAT cycles after accept
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (flush) begin
      state_n = IDLE;
      cnt_n = '0;
    end else if (acc) begin
      state_n = (dec_mul || dec_div) ? EXEC : DONE;
      cnt_n = dec_div ? CW'(DIV_LAT - 2) : dec_mul ? CW'(MUL_LAT - 2) : '0;
    end else if (state == EXEC) begin
      state_n = cnt == '0 ? DONE : EXEC;
      cnt_n = cnt == '0 ? cnt : cnt - 1'b1;
    end else if (state == DONE && out_ready) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      alu_control <= '0;
      m_sel <= '0;
      alu_start <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      alu_start <= acc && (dec_mul || dec_div);
      if (flush) illegal <= 1'b0;
      else if (acc) begin
        alu_control <= dec_ctrl;
        m_sel <= dec_msel;
        illegal <= dec_ill;
      end
    end
  end
endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// tb_alu_ctrl_sequencer: directed scoreboard bench for the ALU control sequencer
module tb_alu_ctrl_sequencer;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [1:0] alu_op = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic in_ready, out_valid, alu_start, busy, illegal;
  logic [4:0] alu_control;
  logic [2:0] m_sel;
  int tests = 0, fails = 0;
  typedef struct {logic [1:0] op; logic [2:0] f3; logic [6:0] f7; logic [4:0] ctrl; logic [2:0] ms; logic ill; int lat;} vec_t;
  typedef struct {logic [4:0] ctrl; logic [2:0] ms; logic ill; int lat;} exp_t;
  vec_t tbl[$];
  exp_t sb[$];
  alu_ctrl_sequencer #(.MUL_LAT(3), .DIV_LAT(34)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .out_valid(out_valid),
    .out_ready(out_ready), .alu_control(alu_control), .m_sel(m_sel),
    .alu_start(alu_start), .busy(busy), .illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic add(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [4:0] ctrl, input logic [2:0] ms, input logic ill, input int lat);
    tbl.push_back('{op, f3, f7, ctrl, ms, ill, lat});
  endtask
  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7);
    alu_op = op;
    funct3 = f3;
    funct7 = f7;
    in_valid = 1'b1;
  endtask
  task automatic watch_no_valid(input string tag, input int cycles);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      seen |= out_valid;
      tick();
    end
    check(tag, seen, 1'b0);
  endtask
  task automatic run_op(input vec_t v);
    int n, busy_n;
    exp_t e;
    check("idle_ready", in_ready, 1'b1);
    drive(v.op, v.f3, v.f7);
    out_ready = 1'b1;
    sb.push_back('{v.ctrl, v.ms, v.ill, v.lat});
    tick();
    in_valid = 1'b0;
    check("alu_start", alu_start, v.lat > 1);
    n = 1;
    busy_n = 0;
    while (!out_valid && n < 300) begin
      busy_n += int'(busy);
      tick();
      n++;
    end
    e = sb.pop_front();
    check("out_valid", out_valid, 1'b1);
    check("latency", n, e.lat);
    check("busy_cycles", busy_n, e.lat - 1);
    check("alu_control", alu_control, e.ctrl);
    check("m_sel", m_sel, e.ms);
    check("illegal", illegal, e.ill);
    tick();
    check("handoff_idle", out_valid, 1'b0);
  endtask
  initial begin
    add(2'b00, 3'b000, 7'b0000000, 5'b00000, 3'b000, 1'b0, 1);
    add(2'b01, 3'b000, 7'b0000000, 5'b11000, 3'b000, 1'b0, 1);
    add(2'b01, 3'b001, 7'b0000000, 5'b11001, 3'b000, 1'b0, 1);
    add(2'b01, 3'b010, 7'b0000000, 5'b00100, 3'b000, 1'b0, 1);
    add(2'b01, 3'b111, 7'b0000000, 5'b11101, 3'b000, 1'b0, 1);
    add(2'b10, 3'b000, 7'b0100000, 5'b00101, 3'b000, 1'b0, 1);
    add(2'b10, 3'b001, 7'b0000000, 5'b10100, 3'b000, 1'b0, 1);
    add(2'b10, 3'b111, 7'b0000000, 5'b10000, 3'b000, 1'b0, 1);
    add(2'b10, 3'b100, 7'b0000001, 5'b01101, 3'b100, 1'b0, 34);
    add(2'b10, 3'b011, 7'b0000001, 5'b01000, 3'b011, 1'b0, 3);
    add(2'b10, 3'b000, 7'b0000001, 5'b01001, 3'b000, 1'b0, 3);
    add(2'b10, 3'b111, 7'b0000001, 5'b01100, 3'b111, 1'b0, 34);
    add(2'b10, 3'b010, 7'b0100000, 5'b00001, 3'b000, 1'b1, 1);
    add(2'b10, 3'b000, 7'b1111111, 5'b00001, 3'b000, 1'b1, 1);
    add(2'b11, 3'b101, 7'b0100000, 5'b10110, 3'b000, 1'b0, 1);
    add(2'b11, 3'b000, 7'b0100000, 5'b00001, 3'b000, 1'b0, 1);
    add(2'b11, 3'b101, 7'b0000000, 5'b10101, 3'b000, 1'b0, 1);
    // reset values, with in_valid and flush asserted to show rst wins
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_ctrl", alu_control, 5'b00000);
    check("rst_msel", m_sel, 3'b000);
    check("rst_start", alu_start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    flush = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_ready", in_ready, 1'b1);
    foreach (tbl[i]) run_op(tbl[i]);
    // MUL held in DONE, then back-to-back ADD with no bubble
    drive(2'b10, 3'b000, 7'b0000001);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("mul_valid", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", out_valid, 1'b1);
      check("hold_ctrl", alu_control, 5'b01001);
      check("hold_msel", m_sel, 3'b000);
      check("hold_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    drive(2'b10, 3'b000, 7'b0000000);
    #1;
    check("b2b_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check("b2b_valid", out_valid, 1'b1);
    check("b2b_ctrl", alu_control, 5'b00001);
    check("b2b_msel", m_sel, 3'b000);
    tick();
    check("b2b_idle", out_valid, 1'b0);
    // DIVU flushed at +10
    drive(2'b10, 3'b101, 7'b0000001);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    check("divu_busy", busy, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", busy, 1'b0);
    check("flush_ready", in_ready, 1'b1);
    watch_no_valid("flush_no_valid", 40);
    // flush coincident with accept drops the op
    drive(2'b10, 3'b000, 7'b0000001);
    flush = 1'b1;
    tick();
    in_valid = 1'b0;
    flush = 1'b0;
    check("flacc_busy", busy, 1'b0);
    check("flacc_start", alu_start, 1'b0);
    watch_no_valid("flacc_no_valid", 10);
    // flush in DONE clears illegal and out_valid
    drive(2'b10, 3'b010, 7'b0100000);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("ill_set", illegal, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("ill_flush", illegal, 1'b0);
    check("ill_flush_valid", out_valid, 1'b0);
    out_ready = 1'b1;
    // reset mid-EXEC discards the op
    drive(2'b10, 3'b100, 7'b0000001);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    check("rx_out_valid", out_valid, 1'b0);
    check("rx_ctrl", alu_control, 5'b00000);
    check("rx_msel", m_sel, 3'b000);
    check("rx_start", alu_start, 1'b0);
    check("rx_busy", busy, 1'b0);
    check("rx_illegal", illegal, 1'b0);
    rst = 1'b0;
    #1;
    check("rx_ready", in_ready, 1'b1);
    watch_no_valid("rx_no_valid", 40);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_sequencer.md
ALU_CTRL_SEQUENCER -- requirements
Module: alu_ctrl_sequencer

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3: cycles from accept to result-valid for multiply ops; legal range 2..255.
REQ-002 SHALL have parameter DIV_LAT, default 34: cycles from accept to result-valid for divide/remainder ops; legal range 2..255.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 flush  input  1  synchronous abort of any held op.
REQ-007 in_valid  input  1  op presented.
REQ-008 in_ready  output  1  op accepted when in_valid and in_ready are both high.
REQ-009 alu_op  input  2  00 mem-add, 01 branch, 10 R-type, 11 I-type.
REQ-010 funct3  input  3  instruction funct3.
REQ-011 funct7  input  7  instruction funct7.
REQ-012 out_valid  output  1  decoded op complete.
REQ-013 out_ready  input  1  consumer takes the result.
REQ-014 alu_control  output  5  ALU op code, held stable from accept until handoff.
REQ-015 m_sel  output  3  M-extension variant (funct3 of the op), else 0.
REQ-016 alu_start  output  1  one-cycle pulse in the cycle after a multi-cycle op is accepted.
REQ-017 busy  output  1  high in EXEC.
REQ-018 illegal  output  1  op was an unsupported R-type encoding.

Function
REQ-019 Decode SHALL map: alu_op 00 -> ADD_UNSIGNED 00000; branch 000/001/100/101/110/111 -> EQ/NE/LT_S/GE_S/LT_U/GE_U (11000/11001/11010/11011/11100/11101), other funct3 -> SUB_UNSIGNED 00100.
REQ-020 R-type funct7=0000000: ADD 00001, SLL 10100, SLT 11010, SLTU 11100, XOR 10010, SRL 10101, OR 10001, AND 10000; funct7=0100000: funct3 000 -> SUB 00101, 101 -> SRA 10110.
REQ-021 R-type funct7=0000001: funct3 000..011 -> MUL_SIGNED 01001 (MULHU 011 -> MUL_UNSIGNED 01000); 100 DIV and 110 REM -> DIV_SIGNED 01101; 101 DIVU and 111 REMU -> DIV_UNSIGNED 01100; m_sel=funct3.
REQ-022 Any other R-type funct7/funct3 pair SHALL set illegal=1, alu_control=ADD_SIGNED 00001, single-cycle.
REQ-023 I-type: as R-type funct7=0 decode; funct3 101 selects SRA when funct7[5]=1; funct7 otherwise ignored; never illegal.
REQ-024 FSM states IDLE, EXEC, DONE; in_ready = !rst && (IDLE || (DONE && out_ready)).
REQ-025 Accept of single-cycle op: register decode, go DONE; out_valid high in the next cycle (latency 1).
REQ-026 Accept of multiply/divide op: register decode, go EXEC, load counter; out_valid first high exactly MUL_LAT or DIV_LAT cycles after the accept cycle.
REQ-027 DONE with out_ready=1 and no new accept -> IDLE; DONE with out_ready=1 and accept -> back-to-back, new op follows REQ-025/026 with no bubble.
REQ-028 DONE with out_ready=0: all outputs held unchanged.
REQ-029 In EXEC, in_valid SHALL be ignored (in_ready=0).
REQ-030 flush SHALL return to IDLE next cycle from any state, clear out_valid/busy/illegal, and take priority over a same-cycle accept or handoff.
REQ-031 Counter width SHALL be the clog2 of the larger latency plus one; no wrap-around at maximum parameter.

Reset
REQ-032 On rst: state IDLE, counter 0, out_valid 0, alu_control 00000, m_sel 000, alu_start 0, busy 0, illegal 0; rst overrides flush and in_valid.
REQ-033 Reset mid-EXEC SHALL discard the op with no late out_valid.

Structure
REQ-034 Package alu_ctrl_pkg SHALL hold all 5-bit ALU codes, ALUOp and funct3/funct7 constants, and the FSM state type.
REQ-035 Combinational decode SHALL be a sub-module alu_ctrl_decode, shared with single-cycle pipelines; the sequencer adds registers, FSM, counter.

Verification
REQ-036 alu_op=10, f3=000, f7=0100000, out_ready=1 -> out_valid at +1, alu_control=00101, busy never high.
REQ-037 alu_op=10, f3=100, f7=0000001, DIV_LAT=34 -> alu_start at +1, busy for cycles +1..+33, out_valid at +34, alu_control=01101, m_sel=100.
REQ-038 MUL (MUL_LAT=3) with out_ready=0 for 5 cycles after completion -> outputs stable, in_ready=0; then out_ready=1 with in_valid ADD -> ADD out_valid next cycle, no bubble.
REQ-039 DIVU accepted, flush at +10 -> IDLE at +11, out_valid never asserted; flush coincident with accept -> op dropped.
REQ-040 alu_op=10, f3=010, f7=0100000 -> illegal=1, alu_control=00001 at +1; alu_op=11, f3=101, f7=0100000 -> 10110, illegal=0.
REQ-041 rst asserted in EXEC -> next cycle all outputs at REQ-032 values, in_ready=1 after rst deasserts.
